// File: rtl/mc_controller.sv
// Multi-cycle RV32I main controller: sequences ALU, memory and immediate select per instruction,
// with a bounded memory-wait timer and sticky traps for illegal opcodes and bus timeouts.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_FETCH     | read instruction at PC, PC+4 -> PC, load IR/oldPC on ready
// S_DECODE    | decode op, precompute branch/jal target into ALUOut
// S_MEM_ADDR  | rs1 + imm -> ALUOut (load/store address)
// S_MEM_READ  | load access at ALUOut, wait for mem_ready
// S_MEM_WB    | memory data -> rd
// S_MEM_WRITE | store access at ALUOut, wait for mem_ready
// S_EXEC_R    | rs1 op rs2
// S_EXEC_I    | rs1 op imm
// S_LUI       | 0 + U-imm
// S_ALU_WB    | ALUOut -> rd
// S_BRANCH    | compare rs1/rs2, conditionally load PC from ALUOut
// S_JAL       | PC <- target, oldPC+4 into ALUOut for link
// S_TRAP      | halted after illegal opcode or bus timeout, until reset

module mc_controller #(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [2:0] imm_sel,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       illegal,
   output logic       bus_err
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_EXEC_R, S_EXEC_I, S_LUI, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             illegal_q, bus_err_q;
   logic             set_illegal, set_bus_err;
   logic             mem_wait, timeout;

   logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_write_s, reg_write_s;
   logic [2:0] imm_sel_s;
   logic [1:0] alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;

   assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
   assign timeout  = mem_wait && !mem_ready && (cnt_q == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         // non-wait states hold the counter at zero, so entry into a wait state starts from 0
         cnt_q     <= (mem_wait && !mem_ready && !timeout) ? cnt_q + 1'b1 : '0;
         illegal_q <= illegal_q | set_illegal;
         bus_err_q <= bus_err_q | set_bus_err;
      end
   end

   always_comb begin
      state_d      = state_q;
      set_illegal  = 1'b0;
      set_bus_err  = 1'b0;
      mem_req_s    = 1'b0;
      mem_write_s  = 1'b0;
      adr_src_s    = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      imm_sel_s    = 3'd0;
      alu_src_a_s  = 2'b00;
      alu_src_b_s  = 2'b00;
      alu_op_s     = 2'b00;
      result_src_s = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req_s    = 1'b1;
            alu_src_b_s  = 2'b10;
            result_src_s = 2'b10;
            if (mem_ready) begin
               ir_write_s = 1'b1;
               pc_write_s = 1'b1;
               state_d    = S_DECODE;
            end else if (timeout) begin
               set_bus_err = 1'b1;
               state_d     = S_TRAP;
            end
         end
         S_DECODE: begin
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b01;
            imm_sel_s   = (op == OP_JAL) ? 3'd4 : 3'd2;
            case (op)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_LUI:       state_d = S_LUI;
               default: begin
                  set_illegal = 1'b1;
                  state_d     = S_TRAP;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
            imm_sel_s   = (op == OP_SW) ? 3'd1 : 3'd0;
            state_d     = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_req_s = 1'b1;
            adr_src_s = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (timeout) begin
               set_bus_err = 1'b1;
               state_d     = S_TRAP;
            end
         end
         S_MEM_WB: begin
            result_src_s = 2'b01;
            reg_write_s  = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_req_s   = 1'b1;
            mem_write_s = 1'b1;
            adr_src_s   = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (timeout) begin
               set_bus_err = 1'b1;
               state_d     = S_TRAP;
            end
         end
         S_EXEC_R: begin
            alu_src_a_s = 2'b10;
            alu_op_s    = 2'b10;
            state_d     = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
            alu_op_s    = 2'b10;
            state_d     = S_ALU_WB;
         end
         S_LUI: begin
            alu_src_a_s = 2'b11;
            alu_src_b_s = 2'b01;
            imm_sel_s   = 3'd3;
            state_d     = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_s = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_s = 2'b10;
            alu_op_s    = 2'b01;
            state_d     = S_FETCH;
            case (funct3)
               3'b000:  pc_write_s = zero;
               3'b001:  pc_write_s = ~zero;
               default: begin
                  set_illegal = 1'b1;
                  state_d     = S_TRAP;
               end
            endcase
         end
         S_JAL: begin
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b10;
            pc_write_s  = 1'b1;
            state_d     = S_ALU_WB;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // reset forces every control output low at once, even though the state register sits in FETCH
   assign mem_req    = rst_n & mem_req_s;
   assign mem_write  = rst_n & mem_write_s;
   assign adr_src    = rst_n & adr_src_s;
   assign ir_write   = rst_n & ir_write_s;
   assign pc_write   = rst_n & pc_write_s;
   assign reg_write  = rst_n & reg_write_s;
   assign imm_sel    = {3{rst_n}} & imm_sel_s;
   assign alu_src_a  = {2{rst_n}} & alu_src_a_s;
   assign alu_src_b  = {2{rst_n}} & alu_src_b_s;
   assign alu_op     = {2{rst_n}} & alu_op_s;
   assign result_src = {2{rst_n}} & result_src_s;
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle expected control vectors are queued as stimulus is applied
// and popped mid-cycle for comparison against the DUT outputs.

module tb_mc_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [2:0] imm_sel;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic       illegal, bus_err;

   int n_cmp = 0;
   int n_err = 0;
   logic [18:0] sb[$];
   logic [18:0] obs;

   mc_controller #(.WAIT_LIMIT(255), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
      .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_sel,
                 alu_src_a, alu_src_b, alu_op, result_src, illegal, bus_err};

   function automatic logic [18:0] pk(input logic mr, input logic mw, input logic as,
      input logic irw, input logic pcw, input logic rw, input logic [2:0] imm,
      input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop, input logic [1:0] rs,
      input logic ill, input logic be);
      return {mr, mw, as, irw, pcw, rw, imm, a, b, aop, rs, ill, be};
   endfunction

   function automatic logic [18:0] v_fetch(input logic rdy);
      return pk(1, 0, 0, rdy, rdy, 0, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0);
   endfunction

   function automatic logic [18:0] v_decode(input logic [2:0] imm);
      return pk(0, 0, 0, 0, 0, 0, imm, 2'd1, 2'd1, 2'd0, 2'd0, 0, 0);
   endfunction

   function automatic logic [18:0] v_alu_wb();
      return pk(0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
   endfunction

   function automatic logic [18:0] v_trap(input logic ill, input logic be);
      return pk(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, ill, be);
   endfunction

   // apply one cycle of inputs, queue what the outputs must be, move to mid-cycle
   task automatic drv(input logic rdy, input logic z, input logic [18:0] exp);
      mem_ready = rdy;
      zero      = z;
      sb.push_back(exp);
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [18:0] e;
      #3;
      sb.push_back(19'd0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want %h", obs, e);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drv(1'b0, 1'b0, v_fetch(1'b0));
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL reset_fetch_wait cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
   endtask

   task automatic test_r_type();
      logic [18:0] ex[4];
      logic [18:0] e;
      op = 7'b0110011;
      funct3 = 3'b000;
      ex = '{v_fetch(1'b1), v_decode(3'd2),
             pk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0), v_alu_wb()};
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b0, ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL r_type cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
   endtask

   task automatic test_alu_imm();
      logic [18:0] ex[4];
      logic [18:0] e;
      for (int t = 0; t < 2; t++) begin
         op = (t == 0) ? 7'b0010011 : 7'b0110111;
         funct3 = 3'b000;
         ex = '{v_fetch(1'b1), v_decode(3'd2),
                (t == 0) ? pk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 2'd2, 2'd0, 0, 0)
                         : pk(0, 0, 0, 0, 0, 0, 3'd3, 2'd3, 2'd1, 2'd0, 2'd0, 0, 0),
                v_alu_wb()};
         for (int i = 0; i < 4; i++) begin
            drv((i == 0) ? 1'b1 : 1'b0, 1'b0, ex[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL %s cyc%0d: got %h want %h", (t == 0) ? "exec_i" : "lui", i, obs, e);
            end
            adv();
         end
      end
   endtask

   task automatic test_lw_wait();
      logic [18:0] ex[8];
      logic        rd[8];
      logic [18:0] e;
      logic [18:0] mrd;
      op = 7'b0000011;
      funct3 = 3'b010;
      mrd = pk(1, 0, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
      ex = '{v_fetch(1'b1), v_decode(3'd2),
             pk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0),
             mrd, mrd, mrd, mrd,
             pk(0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 0, 0)};
      rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         drv(rd[i], 1'b0, ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL lw_wait cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
   endtask

   task automatic test_sw();
      logic [18:0] ex[4];
      logic [18:0] e;
      op = 7'b0100011;
      funct3 = 3'b010;
      ex = '{v_fetch(1'b1), v_decode(3'd2),
             pk(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0),
             pk(1, 1, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         drv((i == 0 || i == 3) ? 1'b1 : 1'b0, 1'b0, ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL sw cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
   endtask

   task automatic test_branch();
      logic [2:0]  f3[4];
      logic        zz[4];
      logic        pw[4];
      logic [18:0] ex[3];
      logic [18:0] e;
      f3 = '{3'b000, 3'b001, 3'b000, 3'b001};
      zz = '{1'b1, 1'b1, 1'b0, 1'b0};
      pw = '{1'b1, 1'b0, 1'b0, 1'b1};
      op = 7'b1100011;
      for (int t = 0; t < 4; t++) begin
         funct3 = f3[t];
         ex = '{v_fetch(1'b1), v_decode(3'd2),
                pk(0, 0, 0, 0, pw[t], 0, 3'd0, 2'd2, 2'd0, 2'd1, 2'd0, 0, 0)};
         for (int i = 0; i < 3; i++) begin
            drv((i == 0) ? 1'b1 : 1'b0, zz[t], ex[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
               n_err++;
               $display("FAIL branch f3=%0d zero=%0d cyc%0d: got %h want %h",
                        f3[t], zz[t], i, obs, e);
            end
            adv();
         end
      end
   endtask

   task automatic test_jal();
      logic [18:0] ex[4];
      logic [18:0] e;
      op = 7'b1101111;
      funct3 = 3'b000;
      ex = '{v_fetch(1'b1), v_decode(3'd4),
             pk(0, 0, 0, 0, 1, 0, 3'd0, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0), v_alu_wb()};
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b0, ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL jal cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
   endtask

   task automatic test_illegal();
      logic [18:0] ex[5];
      logic [18:0] e;
      op = 7'b1111111;
      funct3 = 3'b000;
      ex = '{v_fetch(1'b1), v_decode(3'd2), v_trap(1'b1, 1'b0), v_trap(1'b1, 1'b0),
             v_trap(1'b1, 1'b0)};
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 1'b0, ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL illegal_op cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
      do_reset();
      op = 7'b1100011;
      funct3 = 3'b010;
      ex = '{v_fetch(1'b1), v_decode(3'd2),
             pk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd0, 2'd1, 2'd0, 0, 0),
             v_trap(1'b1, 1'b0), v_trap(1'b1, 1'b0)};
      for (int i = 0; i < 5; i++) begin
         drv((i == 0) ? 1'b1 : 1'b0, 1'b1, ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL illegal_branch cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
      do_reset();
   endtask

   task automatic test_bus_err();
      logic [18:0] e;
      op = 7'b0110011;
      funct3 = 3'b000;
      // 255 idle cycles then ready on the limit cycle: normal completion
      for (int i = 0; i < 256; i++) begin
         drv((i == 255) ? 1'b1 : 1'b0, 1'b0, v_fetch((i == 255) ? 1'b1 : 1'b0));
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL fetch_limit_ready cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
      drv(1'b0, 1'b0, v_decode(3'd2));
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL limit_ready_decode: got %h want %h", obs, e);
      end
      adv();
      repeat (2) adv();
      for (int i = 0; i < 258; i++) begin
         drv(1'b0, 1'b0, (i < 256) ? v_fetch(1'b0) : v_trap(1'b0, 1'b1));
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL fetch_timeout cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
      do_reset();
      drv(1'b0, 1'b0, v_fetch(1'b0));
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL bus_err_cleared: got %h want %h", obs, e);
      end
      adv();
   endtask

   task automatic test_reset_midway();
      logic [18:0] ex[4];
      logic [18:0] e;
      op = 7'b0100011;
      funct3 = 3'b010;
      ex = '{v_fetch(1'b1), v_decode(3'd2),
             pk(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0),
             pk(1, 1, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         drv((i == 0) ? 1'b1 : 1'b0, 1'b0, ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL sw_before_reset cyc%0d: got %h want %h", i, obs, e);
         end
         if (i < 3) adv();
      end
      #1 rst_n = 1'b0;
      sb.push_back(19'd0);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL reset_in_mem_write: got %h want %h", obs, e);
      end
      adv();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drv(1'b0, 1'b0, v_fetch(1'b0));
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL fetch_after_reset cyc%0d: got %h want %h", i, obs, e);
         end
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_alu_imm();
      test_lw_wait();
      test_sw();
      test_branch();
      test_jal();
      test_illegal();
      test_bus_err();
      test_reset_midway();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
